memory_loader_unit: RTL and testbench
=====================================

MEMORY_LOADER_UNIT -- requirements
Module: memory_loader_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data word width.
REQ-002 SHALL have parameter MEM_ADDR_SIZE, default 5, address width; depth = 2**MEM_ADDR_SIZE words.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_address  input  MEM_ADDR_SIZE  CPU word address.
REQ-006 SHALL have port mem_write_data  input  WORD_SIZE  CPU store data.
REQ-007 SHALL have port mem_read  input  1  CPU read strobe.
REQ-008 SHALL have port mem_write  input  1  CPU write strobe.
REQ-009 SHALL have port mem_read_data  output  WORD_SIZE  read data returned to CPU.
REQ-010 SHALL have port load_start  input  1  one-cycle request to begin a program load.
REQ-011 SHALL have port load_valid  input  1  load_data holds a valid program word.
REQ-012 SHALL have port load_data  input  WORD_SIZE  program word from external loader.
REQ-013 SHALL have port load_done  input  1  loader has no further words.
REQ-014 SHALL have port load_ready  output  1  block accepts load words this cycle.
REQ-015 SHALL have port cpu_enable  output  1  memory owned by CPU; CPU may run.
REQ-016 SHALL have port load_count  output  MEM_ADDR_SIZE+1  number of words accepted in current/last load.
REQ-017 SHALL have port access_error  output  1  sticky illegal-access flag.

Function
REQ-018 SHALL implement FSM states IDLE, LOADING, RUNNING.
REQ-019 IDLE -> LOADING on load_start; load_count cleared to 0 and access_error cleared on the same edge.
REQ-020 LOADING: word accepted when load_valid && load_ready; written to address load_count[MEM_ADDR_SIZE-1:0]; load_count +1 on that edge.
REQ-021 LOADING -> RUNNING on the edge where load_done=1, or where the accepted word is the last address (load_count becomes 2**MEM_ADDR_SIZE); a word accepted with load_done in the same cycle SHALL be written before transition.
REQ-022 load_done in LOADING with load_count=0 and no valid word -> RUNNING with load_count=0; memory contents unchanged.
REQ-023 load_ready SHALL be 1 exactly while state is LOADING (combinational from state).
REQ-024 cpu_enable SHALL be 1 exactly while state is RUNNING (registered state, no combinational input path).
REQ-025 RUNNING -> LOADING on load_start (reload); load_count and access_error cleared; cpu_enable low from next cycle.
REQ-026 load_start in LOADING SHALL be ignored (no count reset).
REQ-027 Reads combinational: mem_read_data = mem[mem_address] when state RUNNING and mem_read=1, else 0.
REQ-028 Writes synchronous: mem[mem_address] <= mem_write_data on edge when RUNNING, mem_write=1, mem_read=0.
REQ-029 Read of the address being written in the same cycle SHALL return old contents.
REQ-030 access_error SHALL set on edge where (mem_read||mem_write) and state != RUNNING, or mem_read && mem_write in RUNNING; the write SHALL then be suppressed.
REQ-031 access_error SHALL stay set until reset or load_start.
REQ-032 load_valid, load_data, load_done SHALL be ignored outside LOADING; CPU strobes SHALL never modify memory outside RUNNING.
REQ-033 load_count SHALL saturate at 2**MEM_ADDR_SIZE; no address wrap-around write.

Reset
REQ-034 On reset=1, immediately and independent of clock: state IDLE, load_count 0, access_error 0, cpu_enable 0, load_ready 0, mem_read_data 0.
REQ-035 Reset SHALL NOT clear memory array contents; reset mid-load leaves already-written words intact.
REQ-036 After reset deasserts, state SHALL remain IDLE until load_start.

Verification
REQ-037 Reset, load_start, 3 words 0x1111/0x2222/0x3333 then load_done -> load_count=3, cpu_enable=1; read addr 1 -> 0x2222.
REQ-038 Stream 32 valid words without load_done -> RUNNING after 32nd word, load_count=32, addr 31 holds word 32, addr 0 not overwritten.
REQ-039 RUNNING: write 0xBEEF to addr 5 while reading addr 5 same cycle -> old value read; next cycle reads 0xBEEF.
REQ-040 mem_read in IDLE -> mem_read_data=0, access_error=1 next edge; mem_read+mem_write in RUNNING -> write suppressed, access_error=1; load_start clears it.
REQ-041 Assert reset after 2 of 4 load words -> all outputs 0 asynchronously, state IDLE; after reload with load_done only, addr 0/1 retain first two words.
REQ-042 load_valid with load_done same cycle as 4th word -> word written at addr 3, load_count=4, cpu_enable=1 next cycle.

Source files
------------

// File: rtl/memory_loader_unit.sv
// Program-memory owner: an external loader streams words in while LOADING,
// then the CPU gets exclusive read/write access while RUNNING.
module memory_loader_unit #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_SIZE = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [MEM_ADDR_SIZE-1:0] mem_address,
  input  logic [WORD_SIZE-1:0]     mem_write_data,
  input  logic                     mem_read,
  input  logic                     mem_write,
  output logic [WORD_SIZE-1:0]     mem_read_data,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [WORD_SIZE-1:0]     load_data,
  input  logic                     load_done,
  output logic                     load_ready,
  output logic                     cpu_enable,
  output logic [MEM_ADDR_SIZE:0]   load_count,
  output logic                     access_error
);

  localparam int DEPTH = 2 ** MEM_ADDR_SIZE;
  localparam logic [MEM_ADDR_SIZE:0] FULL_COUNT = {1'b1, {MEM_ADDR_SIZE{1'b0}}};
  localparam logic [MEM_ADDR_SIZE:0] LAST_COUNT = {1'b0, {MEM_ADDR_SIZE{1'b1}}};
  localparam logic [MEM_ADDR_SIZE:0] ONE_COUNT  = {{MEM_ADDR_SIZE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    RUNNING = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   next_state_s;
  logic [WORD_SIZE-1:0]     mem_r [0:DEPTH-1];
  logic [MEM_ADDR_SIZE:0]   load_count_r;
  logic                     access_error_r;
  logic                     cpu_enable_r;
  logic [WORD_SIZE-1:0]     read_data_s;
  logic                     start_s;
  logic                     accept_s;
  logic                     cpu_write_s;
  logic                     error_s;

  // Qualify strobes: load_start only acts outside LOADING, and a saturated count never accepts.
  always_comb begin
    start_s     = load_start && (state_r != LOADING);
    accept_s    = (state_r == LOADING) && load_valid && (load_count_r != FULL_COUNT);
    cpu_write_s = (state_r == RUNNING) && mem_write && !mem_read;
    if (state_r == RUNNING) begin
      error_s = mem_read && mem_write;
    end else begin
      error_s = mem_read || mem_write;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_start) begin
          next_state_s = LOADING;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOADING: begin
        if (load_done || (accept_s && (load_count_r == LAST_COUNT))) begin
          next_state_s = RUNNING;
        end else begin
          next_state_s = LOADING;
        end
      end
      RUNNING: begin
        if (load_start) begin
          next_state_s = LOADING;
        end else begin
          next_state_s = RUNNING;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register; cpu_enable is a flop tracking the RUNNING state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cpu_enable_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      cpu_enable_r <= (next_state_s == RUNNING);
    end
  end

  // Load word counter and sticky access error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_count_r   <= {(MEM_ADDR_SIZE+1){1'b0}};
      access_error_r <= 1'b0;
    end else begin
      if (start_s) begin
        load_count_r <= {(MEM_ADDR_SIZE+1){1'b0}};
      end else if (accept_s) begin
        load_count_r <= load_count_r + ONE_COUNT;
      end
      if (start_s) begin
        access_error_r <= 1'b0;
      end else if (error_s) begin
        access_error_r <= 1'b1;
      end
    end
  end

  // Memory array is deliberately not reset; writes are gated by the async-reset state.
  always_ff @(posedge clock) begin
    if (accept_s) begin
      mem_r[load_count_r[MEM_ADDR_SIZE-1:0]] <= load_data;
    end else if (cpu_write_s) begin
      mem_r[mem_address] <= mem_write_data;
    end
  end

  // Combinational read port, returns pre-write contents during a same-cycle write.
  always_comb begin
    if ((state_r == RUNNING) && mem_read) begin
      read_data_s = mem_r[mem_address];
    end else begin
      read_data_s = {WORD_SIZE{1'b0}};
    end
  end

  assign mem_read_data = read_data_s;
  assign load_ready    = (state_r == LOADING);
  assign cpu_enable    = cpu_enable_r;
  assign load_count    = load_count_r;
  assign access_error  = access_error_r;

endmodule

// File: tb/tb_memory_loader_unit.sv
// Directed self-checking bench for memory_loader_unit with hand-computed expectations.
module tb_memory_loader_unit;

  logic        clock;
  logic        reset;
  logic [4:0]  mem_address;
  logic [15:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_read_data;
  logic        load_start;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_done;
  logic        load_ready;
  logic        cpu_enable;
  logic [5:0]  load_count;
  logic        access_error;

  int n_checks = 0;
  int n_pass   = 0;

  memory_loader_unit #(.WORD_SIZE(16), .MEM_ADDR_SIZE(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data),
    .load_start     (load_start),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_done      (load_done),
    .load_ready     (load_ready),
    .cpu_enable     (cpu_enable),
    .load_count     (load_count),
    .access_error   (access_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [15:0] data, input logic done);
    load_valid = 1'b1;
    load_data  = data;
    load_done  = done;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr, input logic [15:0] exp);
    mem_address = addr;
    mem_read    = 1'b1;
    #1;
    check_eq(tag, {16'h0000, mem_read_data}, {16'h0000, exp});
    mem_read = 1'b0;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, {31'd0, load_ready}, 32'd0);
    check_eq({tag, "_cpu_en"}, {31'd0, cpu_enable}, 32'd0);
    check_eq({tag, "_count"}, {26'd0, load_count}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, access_error}, 32'd0);
    check_eq({tag, "_rdata"}, {16'd0, mem_read_data}, 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    mem_address    = 5'd0;
    mem_write_data = 16'h0000;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    load_start     = 1'b0;
    load_valid     = 1'b0;
    load_data      = 16'h0000;
    load_done      = 1'b0;
    #3;
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_eq("idle_holds_ready", {31'd0, load_ready}, 32'd0);
    check_eq("idle_holds_cpu_en", {31'd0, cpu_enable}, 32'd0);

    // Three-word load terminated by load_done.
    start_load();
    check_eq("load1_ready", {31'd0, load_ready}, 32'd1);
    check_eq("load1_count0", {26'd0, load_count}, 32'd0);
    load_word(16'h1111, 1'b0);
    load_word(16'h2222, 1'b0);
    load_word(16'h3333, 1'b0);
    check_eq("load1_count3_loading", {26'd0, load_count}, 32'd3);
    check_eq("load1_cpu_en_low", {31'd0, cpu_enable}, 32'd0);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check_eq("load1_count", {26'd0, load_count}, 32'd3);
    check_eq("load1_cpu_en", {31'd0, cpu_enable}, 32'd1);
    check_eq("load1_ready_low", {31'd0, load_ready}, 32'd0);
    read_check("load1_addr1", 5'd1, 16'h2222);
    read_check("load1_addr0", 5'd0, 16'h1111);
    read_check("load1_addr2", 5'd2, 16'h3333);

    // Full 32-word stream auto-terminates at the last address.
    tick();
    start_load();
    check_eq("full_reload_count0", {26'd0, load_count}, 32'd0);
    check_eq("full_reload_cpu_en", {31'd0, cpu_enable}, 32'd0);
    for (int i = 0; i < 31; i++) begin
      load_valid = 1'b1;
      load_data  = 16'hA000 + 16'(i);
      tick();
    end
    check_eq("full_count31", {26'd0, load_count}, 32'd31);
    check_eq("full_still_loading", {31'd0, load_ready}, 32'd1);
    load_data = 16'hA01F;
    tick();
    check_eq("full_count32", {26'd0, load_count}, 32'd32);
    check_eq("full_cpu_en", {31'd0, cpu_enable}, 32'd1);
    load_data = 16'hFFFF;
    tick();
    load_valid = 1'b0;
    check_eq("full_saturated", {26'd0, load_count}, 32'd32);
    read_check("full_addr31", 5'd31, 16'hA01F);
    read_check("full_addr0", 5'd0, 16'hA000);

    // CPU write to addr 5: old value visible before the edge, new value after.
    tick();
    read_check("rw_addr5_old", 5'd5, 16'hA005);
    mem_address    = 5'd5;
    mem_write_data = 16'hBEEF;
    mem_write      = 1'b1;
    mem_read       = 1'b1;
    #1;
    check_eq("rw_same_cycle_old", {16'd0, mem_read_data}, {16'd0, 16'hA005});
    mem_read = 1'b0;
    tick();
    mem_write = 1'b0;
    check_eq("rw_no_error", {31'd0, access_error}, 32'd0);
    read_check("rw_addr5_new", 5'd5, 16'hBEEF);

    // Simultaneous read and write in RUNNING: error, write suppressed.
    tick();
    mem_address    = 5'd7;
    mem_write_data = 16'h1234;
    mem_read       = 1'b1;
    mem_write      = 1'b1;
    tick();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check_eq("rw_both_err", {31'd0, access_error}, 32'd1);
    read_check("rw_both_suppressed", 5'd7, 16'hA007);
    tick();
    check_eq("err_sticky", {31'd0, access_error}, 32'd1);

    // Reload with load_done only clears error and leaves memory intact.
    start_load();
    check_eq("reload_err_clear", {31'd0, access_error}, 32'd0);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check_eq("empty_load_cpu_en", {31'd0, cpu_enable}, 32'd1);
    check_eq("empty_load_count", {26'd0, load_count}, 32'd0);
    read_check("empty_load_addr7", 5'd7, 16'hA007);

    // Async reset in the middle of a four-word load.
    tick();
    start_load();
    load_word(16'h0C01, 1'b0);
    load_word(16'h0C02, 1'b0);
    check_eq("midload_count2", {26'd0, load_count}, 32'd2);
    load_valid = 1'b1;
    load_data  = 16'h0C03;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    tick();
    load_valid = 1'b0;
    reset      = 1'b0;
    tick();
    check_eq("post_reset_idle", {31'd0, load_ready}, 32'd0);

    // CPU read in IDLE returns zero and raises the error flag.
    mem_address = 5'd0;
    mem_read    = 1'b1;
    #1;
    check_eq("idle_read_zero", {16'd0, mem_read_data}, 32'd0);
    tick();
    mem_read = 1'b0;
    check_eq("idle_read_err", {31'd0, access_error}, 32'd1);
    start_load();
    check_eq("idle_start_clears_err", {31'd0, access_error}, 32'd0);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    read_check("retain_addr0", 5'd0, 16'h0C01);
    read_check("retain_addr1", 5'd1, 16'h0C02);
    read_check("retain_addr2", 5'd2, 16'hA002);

    // Last word arrives together with load_done; load_start mid-load is ignored.
    tick();
    start_load();
    load_word(16'h4441, 1'b0);
    load_word(16'h4442, 1'b0);
    load_start = 1'b1;
    load_word(16'h4443, 1'b0);
    load_start = 1'b0;
    check_eq("start_ignored_count", {26'd0, load_count}, 32'd3);
    check_eq("start_ignored_ready", {31'd0, load_ready}, 32'd1);
    load_word(16'h4444, 1'b1);
    check_eq("done_with_word_count", {26'd0, load_count}, 32'd4);
    check_eq("done_with_word_cpu_en", {31'd0, cpu_enable}, 32'd1);
    read_check("done_with_word_addr3", 5'd3, 16'h4444);
    read_check("done_with_word_addr4", 5'd4, 16'hA004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
